// File: rtl/fifo_burst_reader.sv
// Burst read master for a synchronous FIFO: issues a programmed number of reads
// and forwards the returned words on a valid/ready stream through a 2-entry buffer.
module fifo_burst_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_underflow_i,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_last_o,
  input  logic             m_ready_i,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] issue_left_q;
  logic [LEN_W-1:0] out_left_q;
  logic [WIDTH-1:0] buf0_q;
  logic [WIDTH-1:0] buf1_q;
  logic [1:0]       occ_q;
  logic             inflight_q;
  logic             err_q;

  logic             pop;
  logic             rd_en;
  logic [2:0]       level;

  // Issue a read only if the word will still have a buffer slot when it lands.
  always_comb begin
    pop   = (occ_q != 2'd0) && m_ready_i;
    level = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    rd_en = (state_q == READ) && (issue_left_q != '0) && !fifo_empty_i && (level < 3'd2);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      issue_left_q <= '0;
      out_left_q   <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      inflight_q <= rd_en;

      // Buffer head is buf0; capture goes to the slot behind any word still held.
      case ({inflight_q, pop})
        2'b10: begin
          if (occ_q == 2'd0) buf0_q <= fifo_rdata_i;
          else               buf1_q <= fifo_rdata_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) buf0_q <= buf1_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_q <= fifo_rdata_i;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= fifo_rdata_i;
          end
        end
        default: ;
      endcase

      if (rd_en && (issue_left_q != '0)) issue_left_q <= issue_left_q - LEN_W'(1);
      if (pop && (out_left_q != '0))     out_left_q   <= out_left_q - LEN_W'(1);

      if (((state_q == READ) || (state_q == DRAIN)) && fifo_underflow_i) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            err_q <= 1'b0;
            if (len_i != '0) begin
              issue_left_q <= len_i;
              out_left_q   <= len_i;
              state_q      <= READ;
            end else begin
              state_q <= DONE;
            end
          end
        end
        READ:    if (rd_en && (issue_left_q == LEN_W'(1))) state_q <= DRAIN;
        DRAIN:   if (pop && (out_left_q == LEN_W'(1)))     state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign busy_o       = (state_q == READ) || (state_q == DRAIN);
  assign done_o       = (state_q == DONE);
  assign m_valid_o    = (occ_q != 2'd0);
  assign m_data_o     = buf0_q;
  assign m_last_o     = (occ_q != 2'd0) && (out_left_q == LEN_W'(1));
  assign err_o        = err_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader with a behavioural FIFO and stream reference.
module tb_fifo_burst_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len_in;
  logic             busy, done, rd_en;
  logic [WIDTH-1:0] rdata = '0;
  logic             fifo_empty;
  logic             fifo_ul;
  logic             m_valid, m_last, m_ready, err;
  logic [WIDTH-1:0] m_data;

  logic [WIDTH-1:0] mem [0:4095];
  int               wr_ptr = 0;
  int               rd_ptr = 0;
  logic [WIDTH-1:0] late_q [$];

  int total = 0;
  int bad   = 0;

  fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len_in),
    .busy_o(busy), .done_o(done), .fifo_rd_en_o(rd_en),
    .fifo_rdata_i(rdata), .fifo_empty_i(fifo_empty), .fifo_underflow_i(fifo_ul),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last), .m_ready_i(m_ready),
    .err_o(err)
  );

  always #5 clk = ~clk;

  // FIFO model with one-cycle registered read.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (rd_en && (rd_ptr != wr_ptr)) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [WIDTH-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic run_burst(input string name, input int len, input int late_cyc,
                           input int ready_pct, input int stall_n, input int ul_cyc,
                           input int start2_cyc, output int first_hs, output int last_hs);
    int base, got, issued, cyc, stall_left;
    bit done_seen, prev_hold, hs_all_prev, seen_valid, exp_busy, exp_err, exp_done, pop;
    logic [WIDTH-1:0] prev_data;
    logic prev_last;
    base = rd_ptr;
    got = 0; issued = 0; cyc = 0; stall_left = stall_n;
    done_seen = 0; prev_hold = 0; hs_all_prev = 0; seen_valid = 0;
    prev_data = '0; prev_last = 0;
    first_hs = -1; last_hs = -1;
    @(posedge clk); #1;
    start = 1'b1; len_in = LEN_W'(len); m_ready = 1'b1; fifo_ul = 1'b0;
    @(posedge clk); #1;
    len_in = LEN_W'($urandom);
    while (cyc < 400 && !done_seen) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      start = (cyc == start2_cyc);
      if (cyc == start2_cyc) len_in = LEN_W'(5);
      if (cyc == late_cyc) while (late_q.size() > 0) push(late_q.pop_front());
      fifo_ul = (cyc == ul_cyc);
      if (stall_n > 0 && (!seen_valid || stall_left > 0)) begin
        m_ready = 1'b0;
        if (seen_valid) stall_left--;
      end else begin
        m_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end
      @(negedge clk);
      total++;
      if (rd_en && fifo_empty) begin
        bad++; $display("FAIL %s rd_when_empty cyc=%0d rd_en=%b empty=%b", name, cyc, rd_en, fifo_empty);
      end
      if (rd_en) issued++;
      if (prev_hold) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          bad++; $display("FAIL %s hold cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                          name, cyc, m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      exp_busy = (len != 0) && !hs_all_prev;
      total++;
      if (busy !== exp_busy) begin
        bad++; $display("FAIL %s busy cyc=%0d got=%b want=%b", name, cyc, busy, exp_busy);
      end
      exp_err = (ul_cyc >= 0) && (cyc > ul_cyc);
      total++;
      if (err !== exp_err) begin
        bad++; $display("FAIL %s err cyc=%0d got=%b want=%b", name, cyc, err, exp_err);
      end
      if (m_valid) begin
        seen_valid = 1;
        total++;
        if (m_last !== (got == len - 1)) begin
          bad++; $display("FAIL %s last cyc=%0d got=%b want=%b", name, cyc, m_last, (got == len - 1));
        end
      end
      pop = m_valid && m_ready;
      if (pop) begin
        total++;
        if (got >= len) begin
          bad++; $display("FAIL %s extra_word cyc=%0d got=%0d want_max=%0d", name, cyc, got + 1, len);
        end else if (m_data !== mem[base + got]) begin
          bad++; $display("FAIL %s data idx=%0d got=%h want=%h", name, got, m_data, mem[base + got]);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        got++;
      end
      total++;
      if (issued - got > 2) begin
        bad++; $display("FAIL %s outstanding cyc=%0d got=%0d want_max=2", name, cyc, issued - got);
      end
      exp_done = (len == 0) ? (cyc == 0) : (got == len && last_hs == cyc - 1);
      total++;
      if (done !== exp_done) begin
        bad++; $display("FAIL %s done cyc=%0d got=%b want=%b", name, cyc, done, exp_done);
      end
      if (done) done_seen = 1;
      hs_all_prev = (len != 0) && (got == len);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      cyc++;
    end
    total++;
    if (!done_seen) begin
      bad++; $display("FAIL %s timeout got=%0d want=done", name, done_seen);
    end
    total++;
    if (issued !== len || got !== len) begin
      bad++; $display("FAIL %s count reads=%0d words=%0d want=%0d", name, issued, got, len);
    end
    @(posedge clk); #1;
    start = 1'b0; fifo_ul = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    total++;
    if (m_valid || busy || done || rd_en || err !== (ul_cyc >= 0)) begin
      bad++; $display("FAIL %s idle got v=%b b=%b d=%b rd=%b e=%b want 0 0 0 0 %b",
                      name, m_valid, busy, done, rd_en, err, (ul_cyc >= 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len_in = '0; fifo_ul = 1'b0; m_ready = 1'b0;
    #1;
    total++;
    if (busy || done || rd_en || m_valid || m_last || err || m_data !== '0) begin
      bad++; $display("FAIL reset got b=%b d=%b rd=%b v=%b l=%b e=%b data=%h want all 0",
                      busy, done, rd_en, m_valid, m_last, err, m_data);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int f, l;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run_burst("basic", 4, -1, 100, 0, -1, -1, f, l);
    total++;
    if (l - f != 3 || f < 0 || f > 3) begin
      bad++; $display("FAIL basic_rate first=%0d last=%0d want span=3 first<=3", f, l);
    end
  endtask

  task automatic test_backpressure();
    int f, l;
    push(8'h11); push(8'h22); push(8'h33);
    run_burst("backpressure", 3, -1, 100, 5, -1, -1, f, l);
  endtask

  task automatic test_empty_stall();
    int f, l;
    push(8'hA5);
    late_q.push_back(8'hB6); late_q.push_back(8'hC7);
    run_burst("empty_stall", 3, 10, 100, 0, -1, -1, f, l);
  endtask

  task automatic test_zero_and_busy_start();
    int f, l;
    run_burst("zero_len", 0, -1, 100, 0, -1, 0, f, l);
    repeat (8) push(WIDTH'($urandom));
    run_burst("busy_start", 2, -1, 100, 0, -1, 1, f, l);
    while (late_q.size() > 0) void'(late_q.pop_front());
  endtask

  task automatic test_underflow();
    int f, l;
    repeat (6) push(WIDTH'($urandom));
    run_burst("underflow", 6, -1, 70, 0, 1, -1, f, l);
    repeat (2) push(WIDTH'($urandom));
    run_burst("err_clear", 2, -1, 100, 0, -1, -1, f, l);
  endtask

  task automatic test_random();
    int f, l, len, pre;
    for (int i = 0; i < 25; i++) begin
      len = int'($urandom_range(1, 24));
      pre = int'($urandom_range(0, len));
      for (int k = 0; k < pre; k++) push(WIDTH'($urandom));
      for (int k = pre; k < len; k++) late_q.push_back(WIDTH'($urandom));
      run_burst("random", len, int'($urandom_range(0, 15)), int'($urandom_range(30, 100)), 0,
                ($urandom_range(0, 3) == 0) ? 0 : -1, -1, f, l);
    end
  endtask

  task automatic test_reset_mid();
    int hs, n;
    hs = 0; n = 0;
    repeat (8) push(WIDTH'($urandom));
    @(posedge clk); #1;
    start = 1'b1; len_in = LEN_W'(8); m_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (hs < 3 && n < 50) begin
      @(negedge clk);
      if (m_valid && m_ready) hs++;
      n++;
    end
    total++;
    if (hs < 3) begin
      bad++; $display("FAIL reset_mid wait words=%0d want=3", hs);
    end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    total++;
    if (busy || done || rd_en || m_valid || m_last || err || m_data !== '0) begin
      bad++; $display("FAIL reset_mid async got b=%b d=%b rd=%b v=%b l=%b e=%b data=%h want all 0",
                      busy, done, rd_en, m_valid, m_last, err, m_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (m_valid || busy || rd_en || done) begin
        bad++; $display("FAIL reset_mid after c=%0d got v=%b b=%b rd=%b d=%b want 0", c, m_valid, busy, rd_en, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_zero_and_busy_start();
    test_underflow();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
